// File: rtl/mod_down_counter_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mod_down_counter_timer
//  Description : Programmable modulo down-counter/timer. Loads a start value,
//                decrements on enabled cycles and emits a registered one-cycle
//                terminal-count pulse at zero. One-shot or auto-reload. Used
//                for periodic ticks, timeouts and baud/strobe dividers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_down_counter_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             mode_q;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;

    // Control FSM: stop has top priority, then start (which also restarts a
    // running timer), then the normal count/expire behaviour of each state.
    // busy/done are registered alongside the state so they decode it exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (stop) begin
            // Abort wins even if a terminal count was due this cycle.
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (start) begin
            // The start cycle only captures; it never decrements or fires tc.
            state_q  <= ST_RUN;
            count_q  <= load_value;
            reload_q <= load_value;
            mode_q   <= auto_reload;
            tc_q     <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (enable) begin
                        if (count_q != '0) begin
                            count_q <= count_q - 1'b1;
                        end else begin
                            tc_q <= 1'b1;
                            if (mode_q) begin
                                count_q <= reload_q;
                            end else begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    count_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_down_counter_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_down_counter_timer
//  Description : Directed self-checking bench for mod_down_counter_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_down_counter_timer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             stop;
    logic             enable;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    int n_cmp;
    int n_err;

    mod_down_counter_timer #(.WIDTH(WIDTH)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .enable      (enable),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int c, input bit t, input bit b, input bit d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    initial begin
        int  ecnt;
        bit  etc;
        bit  erun;
        n_cmp       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        enable      = 1'b0;
        load_value  = '0;
        auto_reload = 1'b0;

        // Reset state
        #12;
        chk_all("reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();
        chk_all("idle_no_start", 0, 0, 0, 0);

        // 1. One-shot load 3, enable high throughout
        load_value = 8'd3; auto_reload = 1'b0; enable = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("os_load", 3, 0, 1, 0);
        tick(); chk_all("os_2", 2, 0, 1, 0);
        tick(); chk_all("os_1", 1, 0, 1, 0);
        tick(); chk_all("os_0", 0, 0, 1, 0);
        tick(); chk_all("os_tc", 0, 1, 0, 1);
        tick(); chk_all("os_hold", 0, 0, 0, 1);

        // 2. Auto-reload load 2 (started from DONE)
        load_value = 8'd2; auto_reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ar_load", 2, 0, 1, 0);
        ecnt = 2;
        for (int i = 0; i < 9; i++) begin
            if (ecnt == 0) begin etc = 1'b1; ecnt = 2; end
            else begin etc = 1'b0; ecnt = ecnt - 1; end
            tick();
            chk_all($sformatf("ar_%0d", i), ecnt, etc, 1, 0);
        end

        // 3. Gated enable, load 4 one-shot
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("stop_idle", 0, 0, 0, 0);
        load_value = 8'd4; auto_reload = 1'b0; enable = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("gt_load", 4, 0, 1, 0);
        ecnt = 4; erun = 1'b1;
        for (int i = 0; i < 12; i++) begin
            enable = (i % 2 == 0);
            etc = 1'b0;
            if (erun && enable) begin
                if (ecnt == 0) begin etc = 1'b1; erun = 1'b0; end
                else ecnt = ecnt - 1;
            end
            tick();
            chk_all($sformatf("gt_%0d", i), ecnt, etc, erun, !erun);
        end

        // 4. Stop/start collision at count=1, then load 0 one-shot
        load_value = 8'd5; auto_reload = 1'b0; enable = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk_all("col_pre", 1, 0, 1, 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk_all("col", 0, 0, 0, 0);
        load_value = 8'd0; auto_reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("z_load", 0, 0, 1, 0);
        tick();
        chk_all("z_tc", 0, 1, 0, 1);

        // Stop beats a due terminal count (load 0 auto-reload)
        auto_reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_all("z_auto_tc", 0, 1, 1, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("stop_tc_due", 0, 0, 0, 0);

        // 5. Restart at count=5 with load 7, later load_value change ignored
        load_value = 8'd9; auto_reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk_all("rs_pre", 5, 0, 1, 0);
        load_value = 8'd7; start = 1'b1;
        tick();
        start = 1'b0; load_value = 8'd200;
        chk_all("rs_load", 7, 0, 1, 0);
        tick(); chk_all("rs_6", 6, 0, 1, 0);
        tick(); chk_all("rs_5", 5, 0, 1, 0);

        // Restart while count==0 with enable: no tc
        load_value = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_all("rz_pre", 0, 0, 1, 0);
        load_value = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("rz_restart", 3, 0, 1, 0);

        // Full-width auto-reload: period 256 enables
        load_value = 8'd255; auto_reload = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (255) tick();
        chk_all("fw_0", 0, 0, 1, 0);
        tick();
        chk_all("fw_reload", 255, 1, 1, 0);

        // 6. Async reset mid-run at count=100
        load_value = 8'd255; auto_reload = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (155) tick();
        chk_all("ar_pre", 100, 0, 1, 0);
        #2 reset_n = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0);
        #2 reset_n = 1'b1;
        tick();
        chk_all("post_rst_1", 0, 0, 0, 0);
        repeat (3) tick();
        chk_all("post_rst_4", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
